// File: rtl/block_cfg_loader.sv
// block_cfg_loader
// Streams a bitstream of size-bit words into a serial config_cell chain of
// chain_len bits. A load pulses cfg_reset once to clear the chain. It then
// accepts words one at a time and shifts each word out LSB first. When the
// last chain bit has been sent it stops, and it discards any unused tail of
// the final word.
//
// Ports
//   clk         single clock, all state changes on posedge
//   reset       asynchronous active-low reset
//   start       begin a full chain load (only honoured in IDLE)
//   word_in     configuration word from the bitstream source
//   word_valid  word_in holds a valid word
//   word_ready  loader accepts word_in this cycle
//   cfg_reset   one-cycle clear pulse to the chain
//   cfg_shift   shift strobe; chain samples cfg_bit while this is high
//   cfg_bit     serial data to the chain (0 when not shifting)
//   busy        load in progress
//   done        last load completed; held until the next accepted start
module block_cfg_loader #(
   parameter int size      = 32,
   parameter int chain_len = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [size-1:0] word_in,
   input  logic            word_valid,
   output logic            word_ready,
   output logic            cfg_reset,
   output logic            cfg_shift,
   output logic            cfg_bit,
   output logic            busy,
   output logic            done
);

   localparam int BW = (size > 1) ? $clog2(size) : 1;
   localparam int TW = $clog2(chain_len + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [size-1:0] shreg;
   logic [BW-1:0]   bit_idx;
   logic [TW-1:0]   total;
   logic            done_q;
   logic            last_bit;
   logic            word_end;

   // Chain-length limit takes priority over word boundary, so the tail of a
   // partially used final word is dropped.
   assign last_bit = (total == TW'(chain_len - 1));
   assign word_end = (bit_idx == BW'(size - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus Moore output decode. Outputs depend only on registered
   // state and datapath, so an asynchronous reset drops them at once.
   always_comb begin
      state_nxt  = state;
      word_ready = 1'b0;
      cfg_reset  = 1'b0;
      cfg_shift  = 1'b0;
      cfg_bit    = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = CLEAR;
         end
         CLEAR: begin
            cfg_reset = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            word_ready = 1'b1;
            if (word_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            cfg_shift = 1'b1;
            cfg_bit   = shreg[bit_idx];
            if (last_bit)      state_nxt = DONE;
            else if (word_end) state_nxt = LOAD;
         end
         DONE: state_nxt = IDLE;
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bit_idx <= '0;
         total   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) done_q <= 1'b0;
            CLEAR: begin
               bit_idx <= '0;
               total   <= '0;
            end
            LOAD: if (word_valid) begin
               shreg   <= word_in;
               bit_idx <= '0;
            end
            SHIFT: begin
               bit_idx <= bit_idx + 1'b1;
               total   <= total + 1'b1;
               if (last_bit) done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_block_cfg_loader.sv
// tb_block_cfg_loader
// Three loader instances (chain_len 64, 40, 1; size 32) share one clock and
// reset. For every load, the expected serial stream is built as the
// concatenation of the supplied words, LSB first, truncated to chain_len
// bits. A negedge monitor records what the chain would actually capture.
module tb_block_cfg_loader;

   localparam int N = 3;
   localparam int CLS [N] = '{64, 40, 1};

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] start, word_valid, word_ready, cfg_reset, cfg_shift, cfg_bit, busy, done;
   logic [31:0]  win [N];

   int checks = 0;
   int failures = 0;

   int          sidx    [N] = '{default: 0};
   int          rst_cnt [N] = '{default: 0};
   int          badbit  [N] = '{default: 0};
   logic [63:0] bitlog  [N] = '{default: '0};
   logic [31:0] wq [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      block_cfg_loader #(.size(32), .chain_len(CLS[g])) u_dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start[g]),
         .word_in    (win[g]),
         .word_valid (word_valid[g]),
         .word_ready (word_ready[g]),
         .cfg_reset  (cfg_reset[g]),
         .cfg_shift  (cfg_shift[g]),
         .cfg_bit    (cfg_bit[g]),
         .busy       (busy[g]),
         .done       (done[g])
      );
   end

   // Chain-side view: the value present during each cycle is what the chain
   // takes on the following rising edge.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (cfg_reset[i] === 1'b1) begin
            rst_cnt[i]++;
            sidx[i]   = 0;
            bitlog[i] = '0;
         end
         if (cfg_shift[i] === 1'b1) begin
            if (sidx[i] < 64) bitlog[i][sidx[i]] = cfg_bit[i];
            sidx[i]++;
         end else if (cfg_bit[i] !== 1'b0) begin
            badbit[i]++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: word_valid always 1; 1: hold word_valid low 10 cycles in the
   // first LOAD; 2: random word_valid; 3: pulse start in the middle of SHIFT.
   task automatic run_load(input int i, input int mode);
      int          cl, nw, widx, bc, r0, hold, cyc;
      bit          acc, v, hold_ok, injected;
      logic [63:0] expv;
      logic [31:0] w;
      cl   = CLS[i];
      nw   = (cl + 31) / 32;
      expv = '0;
      for (int b = 0; b < cl; b++) begin
         w       = wq[b / 32];
         expv[b] = w[b % 32];
      end
      r0 = rst_cnt[i];
      @(negedge clk); start[i] = 1'b1;
      @(negedge clk); start[i] = 1'b0;
      chk("clear_pulse", cfg_reset[i], 1);
      chk("clear_busy", busy[i], 1);
      chk("done_cleared_on_start", done[i], 0);
      chk("clear_not_ready", word_ready[i], 0);
      widx = 0; bc = 0; hold = 0; hold_ok = 1; injected = 0; cyc = 0;
      while (busy[i] && cyc < 3000) begin
         if (cyc == 1) begin
            chk("ready_two_after_start", word_ready[i], 1);
            chk("cfg_reset_one_cycle", cfg_reset[i], 0);
         end
         v = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (mode == 1 && word_ready[i] && hold < 10) begin
            v = 1'b0;
            hold++;
            hold_ok &= word_ready[i] & ~cfg_shift[i] & (sidx[i] == 0);
         end
         start[i] = (mode == 3 && cfg_shift[i] && sidx[i] >= 10 && !injected);
         if (start[i]) injected = 1'b1;
         word_valid[i] = v;
         win[i] = (widx < wq.size()) ? wq[widx] : $urandom;
         acc = word_ready[i] & v;
         @(negedge clk);
         if (acc) widx++;
         bc++;
         cyc++;
      end
      start[i]      = 1'b0;
      word_valid[i] = 1'b0;
      chk("load_finished_in_budget", cyc < 3000, 1);
      chk("shift_count", sidx[i], cl);
      chk("shifted_bits", bitlog[i], expv);
      chk("single_cfg_reset", rst_cnt[i] - r0, 1);
      chk("words_accepted", widx, nw);
      chk("done_after_load", done[i], 1);
      chk("idle_after_load", busy[i], 0);
      chk("cfg_bit_zero_when_idle", badbit[i], 0);
      if (mode == 0) chk("busy_cycles", bc, cl + nw + 2);
      if (mode == 1) chk("stall_hold", hold_ok && hold == 10, 1);
      if (mode == 3) chk("start_injected", injected, 1);
   endtask

   initial begin
      int cyc, s0;
      reset = 1'b0;
      start = '0;
      word_valid = '0;
      for (int i = 0; i < N; i++) win[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {word_ready, cfg_reset, cfg_shift, cfg_bit, busy, done}, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_start_on_release", busy, 0);

      wq.delete(); wq.push_back(32'h0000_0001); wq.push_back(32'h8000_0000);
      run_load(0, 0);
      wq.delete(); wq.push_back(32'hFFFF_FFFF); wq.push_back(32'h0000_00A5);
      run_load(1, 0);
      wq.delete(); wq.push_back($urandom);
      run_load(2, 0);
      wq.delete(); wq.push_back($urandom); wq.push_back($urandom);
      run_load(0, 1);
      wq.delete(); wq.push_back($urandom); wq.push_back($urandom);
      run_load(0, 3);
      for (int k = 0; k < 4; k++) begin
         wq.delete(); wq.push_back($urandom); wq.push_back($urandom);
         run_load(k % 2, 2);
      end
      wq.delete(); wq.push_back($urandom);
      run_load(2, 2);

      // Abort a load partway through the shift phase.
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      word_valid[0] = 1'b1;
      win[0] = $urandom;
      cyc = 0;
      while (sidx[0] < 20 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_20_shifts", cyc < 200, 1);
      chk("busy_before_abort", busy[0], 1);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_outputs",
          {word_ready[0], cfg_reset[0], cfg_shift[0], cfg_bit[0], busy[0], done[0]}, 0);
      s0 = sidx[0];
      repeat (5) @(negedge clk);
      chk("no_shift_after_reset", sidx[0], s0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("release_no_self_start", busy, 0);
      chk("done_cleared_by_reset", done, 0);
      word_valid[0] = 1'b0;
      wq.delete(); wq.push_back($urandom); wq.push_back($urandom);
      run_load(0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
